modulo_controlador_estoque_rolhas: RTL and testbench

Sequences the cork-stock datapath of the bottling line. It holds the 7-bit cork stock count that drives the stock tens/units encoders and displays. It serves corking requests from the sealing station over a req/ack handshake and drives the corking actuator for a fixed time. Operator refills arrive in batches, and the block raises low-stock and empty alarms.

---
 rtl/modulo_controlador_estoque_rolhas.sv | 130 +++++++++++++
 tb/tb_modulo_controlador_estoque_rolhas.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/modulo_controlador_estoque_rolhas.sv
// Cork-stock controller for the bottling line.
// Keeps the 7-bit cork count and serves sealing requests over a req/ack handshake.
// Drives the corking actuator for T_VEDA cycles per cork and absorbs operator refill batches.
module modulo_controlador_estoque_rolhas #(
    parameter int MAX_ESTOQUE      = 99,
    parameter int LOTE_REPOSICAO   = 15,
    parameter int LIMIAR_REPOSICAO = 5,
    parameter int T_VEDA           = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vedar_req,
    input  logic       carga_rolhas,
    output logic [6:0] estoque,
    output logic       atuador_vedacao,
    output logic       vedar_ack,
    output logic       sem_rolhas,
    output logic       repor_alerta,
    output logic       bloqueado,
    output logic       excesso_carga
);

    localparam int TW = (T_VEDA > 1) ? $clog2(T_VEDA) : 1;

    typedef enum logic [2:0] {
        OCIOSO,
        VEDANDO,
        CONCLUI,
        AGUARDA_BAIXA,
        BLOQUEADO
    } estado_t;

    estado_t       estado;
    logic [TW-1:0] timer;
    logic          carga_q;
    logic          carga_edge;
    logic          decremento;
    logic [7:0]    soma;

    // Refill edge detection, cork commit condition and the unclipped 8-bit stock sum.
    // The cork is committed on the same edge that starts the actuator, so the decrement
    // is taken whenever a request can be served from OCIOSO or BLOQUEADO.
    always_comb begin
        carga_edge = carga_rolhas & ~carga_q;
        decremento = ((estado == OCIOSO) || (estado == BLOQUEADO)) &&
                     vedar_req && (estoque != 7'd0);
        soma       = {1'b0, estoque}
                   + (carga_edge ? 8'(LOTE_REPOSICAO) : 8'd0)
                   - {7'd0, decremento};
    end

    // Stock register with saturation at the ceiling; the clip is flagged for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estoque       <= 7'd0;
            excesso_carga <= 1'b0;
            carga_q       <= 1'b0;
        end else begin
            carga_q <= carga_rolhas;
            if (soma > 8'(MAX_ESTOQUE)) begin
                estoque       <= 7'(MAX_ESTOQUE);
                excesso_carga <= 1'b1;
            end else begin
                estoque       <= soma[6:0];
                excesso_carga <= 1'b0;
            end
        end
    end

    // Handshake sequencer: serve one cork per request, time the actuator, pulse the ack,
    // then insist on a low phase of vedar_req before the next cork.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado          <= OCIOSO;
            timer           <= '0;
            atuador_vedacao <= 1'b0;
            vedar_ack       <= 1'b0;
        end else begin
            vedar_ack <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (vedar_req) begin
                        if (estoque != 7'd0) begin
                            estado          <= VEDANDO;
                            atuador_vedacao <= 1'b1;
                            timer           <= TW'(T_VEDA - 1);
                        end else begin
                            estado <= BLOQUEADO;
                        end
                    end
                end
                BLOQUEADO: begin
                    if (!vedar_req) begin
                        estado <= OCIOSO;
                    end else if (estoque != 7'd0) begin
                        estado          <= VEDANDO;
                        atuador_vedacao <= 1'b1;
                        timer           <= TW'(T_VEDA - 1);
                    end
                end
                VEDANDO: begin
                    if (timer == '0) begin
                        estado          <= CONCLUI;
                        atuador_vedacao <= 1'b0;
                        vedar_ack       <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                CONCLUI: begin
                    estado <= AGUARDA_BAIXA;
                end
                AGUARDA_BAIXA: begin
                    if (!vedar_req) begin
                        estado <= OCIOSO;
                    end
                end
                default: begin
                    estado          <= OCIOSO;
                    atuador_vedacao <= 1'b0;
                end
            endcase
        end
    end

    assign sem_rolhas   = (estoque == 7'd0);
    assign repor_alerta = (estoque <= 7'(LIMIAR_REPOSICAO));
    assign bloqueado    = (estado == BLOQUEADO);

endmodule

// File: tb/tb_modulo_controlador_estoque_rolhas.sv
// Bench for the cork-stock controller: directed handshake, refill and reset steps,
// followed by randomized request/refill traffic compared against a cycle model.
module tb_modulo_controlador_estoque_rolhas;

    localparam int MAXE = 99;
    localparam int LOTE = 15;
    localparam int LIM  = 5;
    localparam int TV   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vedar_req = 1'b0;
    logic       carga_rolhas = 1'b0;
    logic [6:0] estoque;
    logic       atuador_vedacao;
    logic       vedar_ack;
    logic       sem_rolhas;
    logic       repor_alerta;
    logic       bloqueado;
    logic       excesso_carga;

    int checks = 0;
    int errors = 0;

    // Reference model state: cork count, actuator cycles still to run, ack pending,
    // waiting for the request to drop, parked for lack of stock, last refill level.
    int m_stock;
    int m_act_left;
    bit m_ack;
    bit m_wait_low;
    bit m_blocked;
    bit m_exc;
    bit m_carga_prev;

    modulo_controlador_estoque_rolhas #(
        .MAX_ESTOQUE(MAXE), .LOTE_REPOSICAO(LOTE),
        .LIMIAR_REPOSICAO(LIM), .T_VEDA(TV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vedar_req(vedar_req), .carga_rolhas(carga_rolhas),
        .estoque(estoque), .atuador_vedacao(atuador_vedacao), .vedar_ack(vedar_ack),
        .sem_rolhas(sem_rolhas), .repor_alerta(repor_alerta), .bloqueado(bloqueado),
        .excesso_carga(excesso_carga)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_stock = 0; m_act_left = 0; m_ack = 0; m_wait_low = 0;
        m_blocked = 0; m_exc = 0; m_carga_prev = 0;
    endtask

    // One clock edge of the model, using the inputs that were stable across the edge.
    task automatic modelEdge();
        bit edge_c;
        bit dec;
        bit ack_next;
        int s;
        edge_c   = carga_rolhas && !m_carga_prev;
        dec      = 0;
        ack_next = 0;
        if (m_act_left > 0) begin
            m_act_left--;
            if (m_act_left == 0) ack_next = 1;
        end else if (m_ack) begin
            m_wait_low = 1;
        end else if (m_wait_low) begin
            if (!vedar_req) m_wait_low = 0;
        end else if (vedar_req) begin
            if (m_stock > 0) begin
                dec = 1; m_act_left = TV; m_blocked = 0;
            end else begin
                m_blocked = 1;
            end
        end else begin
            m_blocked = 0;
        end
        m_ack = ack_next;
        s = m_stock + (edge_c ? LOTE : 0) - (dec ? 1 : 0);
        m_exc = 0;
        if (s > MAXE) begin
            s = MAXE; m_exc = 1;
        end
        m_stock      = s;
        m_carga_prev = carga_rolhas;
    endtask

    task automatic checkOutput();
        chk("estoque",  8'(estoque),         8'(m_stock));
        chk("atuador",  8'(atuador_vedacao), 8'(m_act_left > 0));
        chk("ack",      8'(vedar_ack),       8'(m_ack));
        chk("sem",      8'(sem_rolhas),      8'(m_stock == 0));
        chk("repor",    8'(repor_alerta),    8'(m_stock <= LIM));
        chk("bloq",     8'(bloqueado),       8'(m_blocked));
        chk("excesso",  8'(excesso_carga),   8'(m_exc));
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        // Reset state
        modelReset();
        #12;
        chk("rst_estoque", 8'(estoque), 8'd0);
        chk("rst_sem", 8'(sem_rolhas), 8'd1);
        chk("rst_repor", 8'(repor_alerta), 8'd1);
        chk("rst_atuador", 8'(atuador_vedacao), 8'd0);
        chk("rst_ack", 8'(vedar_ack), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Request with empty stock parks, refill frees it, decrement on the next edge
        vedar_req = 1'b1;
        applyStimulus();
        chk("dir_bloq", 8'(bloqueado), 8'd1);
        chk("dir_bloq_act", 8'(atuador_vedacao), 8'd0);
        carga_rolhas = 1'b1;
        applyStimulus();
        chk("dir_fill15", 8'(estoque), 8'd15);
        applyStimulus();
        chk("dir_dec14", 8'(estoque), 8'd14);
        chk("dir_act_on", 8'(atuador_vedacao), 8'd1);
        carga_rolhas = 1'b0;
        repeat (3) applyStimulus();
        chk("dir_act_4th", 8'(atuador_vedacao), 8'd1);
        applyStimulus();
        chk("dir_ack", 8'(vedar_ack), 8'd1);
        chk("dir_act_off", 8'(atuador_vedacao), 8'd0);
        repeat (6) applyStimulus();
        chk("dir_no_second", 8'(estoque), 8'd14);
        vedar_req = 1'b0;
        repeat (2) applyStimulus();

        // Held refill button adds a single batch
        carga_rolhas = 1'b1;
        repeat (10) applyStimulus();
        chk("dir_held", 8'(estoque), 8'd29);
        carga_rolhas = 1'b0;
        applyStimulus();

        // Repeated presses saturate at the ceiling
        for (int i = 0; i < 7; i++) begin
            carga_rolhas = 1'b1;
            applyStimulus();
            carga_rolhas = 1'b0;
            applyStimulus();
        end
        chk("dir_sat", 8'(estoque), 8'(MAXE));

        // Press coinciding with the decrement edge at the ceiling
        vedar_req = 1'b1;
        carga_rolhas = 1'b1;
        applyStimulus();
        chk("dir_sat_dec", 8'(estoque), 8'(MAXE));
        chk("dir_sat_exc", 8'(excesso_carga), 8'd1);
        carga_rolhas = 1'b0;
        vedar_req = 1'b0;
        repeat (8) applyStimulus();

        // Randomized traffic: draining phase then refilling phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) vedar_req = ~vedar_req;
            if (i < 400) carga_rolhas = ($urandom_range(0, 199) == 0);
            else         carga_rolhas = ($urandom_range(0, 9) == 0);
            applyStimulus();
        end

        // Asynchronous reset during the actuator phase
        vedar_req = 1'b0;
        carga_rolhas = 1'b1;
        applyStimulus();
        carga_rolhas = 1'b0;
        repeat (8) applyStimulus();
        vedar_req = 1'b1;
        applyStimulus();
        chk("dir_pre_rst_act", 8'(atuador_vedacao), 8'd1);
        applyStimulus();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_act", 8'(atuador_vedacao), 8'd0);
        chk("arst_estoque", 8'(estoque), 8'd0);
        chk("arst_ack", 8'(vedar_ack), 8'd0);
        modelReset();
        vedar_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
